barrido_display: RTL and testbench

BARRIDO_DISPLAY -- requirements
Module: barrido_display

---
 rtl/barrido_display.sv | 74 +++++++
 tb/tb_barrido_display.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/barrido_display.sv
// rtl/barrido_display.sv - four-digit multiplexed 7-segment scan with frame-synchronous data update
module barrido_display #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        lz_en,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic [1:0]  sel,
    output logic        frame_tick
);

    localparam logic [19:0] LAST = 20'(DIV - 1);

    logic [19:0] cnt;
    logic [15:0] pend;
    logic [15:0] active;
    logic        pend_v;
    logic        lz_q;
    logic        digit_tick;
    logic [15:0] upper;
    logic        blank;

    assign digit_tick = (cnt == LAST);
    assign frame_tick = digit_tick && (sel == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sel <= 2'd0;
        end else if (digit_tick) begin
            cnt <= '0;
            sel <= sel + 2'd1;
        end else begin
            cnt <= cnt + 20'd1;
        end
    end

    // Displayed data only moves at frame boundaries so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            pend_v <= 1'b0;
            active <= '0;
            lz_q   <= 1'b0;
        end else if (frame_tick) begin
            lz_q   <= lz_en;
            pend_v <= 1'b0;
            if (load) begin
                active <= data_in;
                pend   <= data_in;
            end else if (pend_v) begin
                active <= pend;
            end
        end else if (load) begin
            pend   <= data_in;
            pend_v <= 1'b1;
        end
    end

    always_comb begin
        upper = active >> {sel, 2'b00};
        digit = upper[3:0];
        blank = lz_q && (sel != 2'd0) && (upper == 16'h0000);
        an    = 4'b1111;
        if (!blank) begin
            an[sel] = 1'b0;
        end
    end

endmodule

// File: tb/tb_barrido_display.sv
// tb/tb_barrido_display.sv - directed and randomized checks of barrido_display against a cycle-count model
module tb_barrido_display;

    localparam int DIV = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] data_in;
    logic        lz_en;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic [1:0]  sel;
    logic        frame_tick;

    barrido_display #(.DIV(DIV)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .data_in(data_in),
        .lz_en(lz_en),
        .digit(digit),
        .an(an),
        .sel(sel),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Model: the scan position follows purely from edges counted since reset release.
    int unsigned ncyc;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    bit          m_pf;
    bit          m_lz;
    bit          cur_lz;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, ncyc);
        end
    endtask

    task automatic model_reset();
        ncyc   = 0;
        m_act  = 16'h0000;
        m_pend = 16'h0000;
        m_pf   = 1'b0;
        m_lz   = 1'b0;
    endtask

    task automatic check_all();
        int          s;
        logic [15:0] up;
        logic [3:0]  e_an;
        bit          blank;
        s     = (ncyc / DIV) % 4;
        up    = m_act >> (4 * s);
        blank = m_lz && (s != 0) && (up == 16'h0000);
        e_an  = blank ? 4'b1111 : ~(4'b0001 << s);
        chk("sel", {14'd0, sel}, 16'(s));
        chk("digit", {12'd0, digit}, {12'd0, up[3:0]});
        chk("an", {12'd0, an}, {12'd0, e_an});
        chk("frame_tick", {15'd0, frame_tick}, {15'd0, ((ncyc % FRAME) == FRAME - 1)});
        chk("an_onehot", {15'd0, ($countones(~an) <= 1)}, 16'd1);
    endtask

    task automatic cyc(input bit ld, input logic [15:0] d);
        load    = ld;
        data_in = d;
        lz_en   = cur_lz;
        @(posedge clk);
        if ((ncyc % FRAME) == FRAME - 1) begin
            m_act = ld ? d : (m_pf ? m_pend : m_act);
            m_pf  = 1'b0;
            m_lz  = cur_lz;
        end else if (ld) begin
            m_pend = d;
            m_pf   = 1'b1;
        end
        ncyc++;
        #1;
        check_all();
        load = 1'b0;
    endtask

    task automatic run_to(input int phase);
        int guard;
        guard = 0;
        while (((ncyc % FRAME) != phase) && (guard < 4 * FRAME)) begin
            cyc(1'b0, 16'h0000);
            guard++;
        end
        chk("run_to_bound", 16'(ncyc % FRAME), 16'(phase));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, {12'd0, an}, 16'h000E);
        chk({tag, "_digit"}, {12'd0, digit}, 16'h0000);
        chk({tag, "_sel"}, {14'd0, sel}, 16'h0000);
        chk({tag, "_ft"}, {15'd0, frame_tick}, 16'h0000);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cur_lz  = 1'b0;
        load    = 1'b0;
        data_in = 16'h0000;
        lz_en   = 1'b0;
        rst_n   = 1'b0;
        model_reset();

        // Reset without any clock edge.
        #2;
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) cyc(1'b0, 16'h0000);
        chk("sel_before_4th", {14'd0, sel}, 16'h0000);
        cyc(1'b0, 16'h0000);
        chk("sel_on_4th", {14'd0, sel}, 16'h0001);

        // Deferred update.
        run_to(8);
        cyc(1'b1, 16'h1234);
        run_to(0);
        for (int i = 0; i < FRAME; i++) begin
            chk("defer_digit", {12'd0, digit}, 16'(4 - i / DIV));
            chk("defer_an", {12'd0, an}, {12'd0, ~(4'b0001 << (i / DIV))});
            cyc(1'b0, 16'h0000);
        end

        // Leading-zero blanking.
        cur_lz = 1'b1;
        run_to(6);
        cyc(1'b1, 16'h0050);
        run_to(0);
        repeat (FRAME) cyc(1'b0, 16'h0000);
        chk("lz_s0_digit", {12'd0, digit}, 16'h0000);
        chk("lz_s0_an", {12'd0, an}, 16'h000E);
        repeat (DIV) cyc(1'b0, 16'h0000);
        chk("lz_s1_digit", {12'd0, digit}, 16'h0005);
        chk("lz_s1_an", {12'd0, an}, 16'h000D);
        repeat (DIV) cyc(1'b0, 16'h0000);
        chk("lz_s2_an", {12'd0, an}, 16'h000F);
        repeat (DIV) cyc(1'b0, 16'h0000);
        chk("lz_s3_an", {12'd0, an}, 16'h000F);

        // Last load within a frame wins.
        cur_lz = 1'b0;
        run_to(3);
        cyc(1'b1, 16'hAAAA);
        run_to(7);
        cyc(1'b1, 16'hBBBB);
        run_to(0);
        for (int i = 0; i < FRAME; i++) begin
            chk("lastwins_digit", {12'd0, digit}, 16'h000B);
            cyc(1'b0, 16'h0000);
        end

        // Load exactly on the frame boundary.
        run_to(FRAME - 1);
        chk("collide_ft", {15'd0, frame_tick}, 16'h0001);
        cyc(1'b1, 16'h9876);
        for (int i = 0; i < FRAME; i++) begin
            chk("collide_digit", {12'd0, digit}, 16'(6 + i / DIV));
            cyc(1'b0, 16'h0000);
        end

        // Reset mid-frame with a load pending.
        run_to(2);
        cyc(1'b1, 16'h5A5A);
        run_to(2 * DIV);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cyc(1'b0, 16'h0000);
            chk("no_stale_digit", {12'd0, digit}, 16'h0000);
        end

        // Randomized loads and blanking enable.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) cur_lz = ~cur_lz;
            cyc(($urandom_range(0, 5) == 0), 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
